hallway_column_sequencer: RTL and testbench
===========================================

# hallway_column_sequencer

Per-column sequencer for the scrolling hallway. On each frame tick it requests a direction decision from `hallwayTracerDirectionUpdater`, applies the returned toggles to the two tracer directions, and steps both tracer positions one pixel under clamp and minimum-gap rules. It then hands the resulting column (x, upper edge, lower edge) to the column renderer over a valid/ready handshake. It owns the tracer position/direction registers that feed the updater.

## Interface
Parameters:
- `SCREEN_H`, 120: rows; legal positions 0..SCREEN_H-1.
- `MIN_GAP`, 26: minimum lower_pos - upper_pos after any step.
- `COLS`, 160: column count; col_x wraps at COLS-1.
- `INIT_UPPER`, 20: reset upper position.
- `INIT_LOWER`, 99: reset lower position.

Ports:
- `clock`  in  1  system clock.
- `reset_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `frame_tick`  in  1  one-cycle pulse requesting the next column.
- `run`  in  1  gameplay active; ticks ignored when 0.
- `toggle_upper`, `toggle_lower`  in  1 each  from updater, registered.
- `dir_enable`  out  1  enable to updater.
- `upper_pos`, `lower_pos`  out  7 each  tracer positions, also fed to updater.
- `upper_dir`, `lower_dir`  out  1 each  0 = moving down (+1), 1 = moving up (-1).
- `col_valid`  out  1  column offer.
- `col_ready`  in  1  renderer accepts.
- `col_x`  out  8  column index.
- `col_upper`, `col_lower`  out  7 each  column edges.
- `busy`  out  1  high in any state but IDLE.
- `overrun`  out  1  one-cycle pulse: tick dropped.

## Operation
- Reset values (asynchronous, immediate):
  - state IDLE; upper_pos=INIT_UPPER, lower_pos=INIT_LOWER.
  - upper_dir=1, lower_dir=0.
  - col_x=0; dir_enable, col_valid, busy, overrun = 0.
  - col_upper/col_lower = reset positions.
- FSM:
  - IDLE: frame_tick & run -> ENABLE.
  - ENABLE: dir_enable=1 for exactly this cycle -> SAMPLE.
  - SAMPLE: upper_dir ^= toggle_upper, lower_dir ^= toggle_lower -> STEP.
  - STEP: position update, latch col_upper/col_lower -> EMIT.
  - EMIT: col_valid=1 until col_valid & col_ready. On handshake col_x += 1 (COLS-1 -> 0) -> IDLE.
- STEP arithmetic: compute in 8-bit signed; never wraps 7-bit.
  - Candidate cu = upper ± 1, cl = lower ± 1 per direction.
  - Top clamp: upper_dir=1 and upper_pos=0 -> cu=0, upper_dir forced 0.
  - Bottom clamp: lower_dir=0 and lower_pos=SCREEN_H-1 -> cl=SCREEN_H-1, lower_dir forced 1.
  - Gap rule, evaluated after clamps: if cl - cu < MIN_GAP, hold upper (cu = upper_pos). If still < MIN_GAP, hold lower too. Directions are not changed by gap holds; the updater resolves them.
  - Invariant at all times: 0 ≤ upper_pos, lower_pos ≤ SCREEN_H-1, and lower_pos - upper_pos ≥ MIN_GAP.
- frame_tick outside IDLE: ignored; overrun=1 next cycle. frame_tick with run=0: ignored, no overrun.
- run dropping mid-sequence does not abort; the current column completes.
- Outputs are stable while col_valid is high and col_ready is low.

## Timing
- All outputs are registered.
- Tick sampled at edge T:
  - dir_enable high in cycle T+1.
  - New dirs visible at T+2 (SAMPLE).
  - Stepped positions visible at T+3 (STEP).
  - col_valid high from cycle T+3 (EMIT entered).
- With col_ready=1, the handshake occurs at that edge and IDLE is re-entered. Minimum tick spacing is 5 cycles.
- Toggles are consumed only in SAMPLE. Toggles in other cycles are don't-care.
- Reset mid-EMIT: col_valid drops asynchronously; no col_x increment.

## Test plan
- Reset: release reset_n -> upper_pos=20, lower_pos=99, upper_dir=1, lower_dir=0, col_x=0, col_valid=0, busy=0.
- One tick, toggles 0, col_ready=1 -> dir_enable high one cycle only; column x=0, upper=19, lower=100; col_x=1 after; busy returns 0.
- 21 ticks, toggles 0 -> after tick 20: 0/119. Tick 21: positions stay 0/119, upper_dir=0, lower_dir=1.
- Tick 1 with both toggles=1, then toggles 0:
  - tick 1 -> 21/98.
  - tick 26 -> 46/73.
  - tick 27 -> 46/72 (upper held).
  - tick 28 -> 46/72 (both held).
  - gap never < 26.
- col_ready low 10 cycles in EMIT -> col_valid and column fields constant; tick during wait -> overrun pulse, no extra column; col_x increments once on handshake.
- 160 ticks -> col_x sequence 0..159, then 0. Assert reset_n mid-EMIT -> immediate reset values, col_valid=0.

Source files
------------

// File: rtl/hallway_column_sequencer.sv
// Per-column tracer sequencer: on a frame tick it asks the updater for direction toggles, steps both tracers, then offers the column.
// Latency: tick sampled at edge T -> dir_enable during T..T+1, dirs updated at T+2, positions/col_valid at T+3.
// Backpressure: col_valid and column fields hold until col_ready; ticks arriving while busy are dropped and flagged on overrun.
module hallway_column_sequencer #(
  parameter int SCREEN_H   = 120,
  parameter int MIN_GAP    = 26,
  parameter int COLS       = 160,
  parameter int INIT_UPPER = 20,
  parameter int INIT_LOWER = 99
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       run,
  input  logic       toggle_upper,
  input  logic       toggle_lower,
  output logic       dir_enable,
  output logic [6:0] upper_pos,
  output logic [6:0] lower_pos,
  output logic       upper_dir,
  output logic       lower_dir,
  output logic       col_valid,
  input  logic       col_ready,
  output logic [7:0] col_x,
  output logic [6:0] col_upper,
  output logic [6:0] col_lower,
  output logic       busy,
  output logic       overrun
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ENABLE = 3'd1;
  localparam logic [2:0] S_SAMPLE = 3'd2;
  localparam logic [2:0] S_STEP   = 3'd3;
  localparam logic [2:0] S_EMIT   = 3'd4;

  localparam logic signed [7:0] GAP_S    = 8'(MIN_GAP);
  localparam logic signed [7:0] BOTTOM_S = 8'(SCREEN_H - 1);
  localparam logic [7:0]        LAST_X   = 8'(COLS - 1);
  localparam logic [6:0]        RST_UP   = 7'(INIT_UPPER);
  localparam logic [6:0]        RST_LO   = 7'(INIT_LOWER);

  logic [2:0] state_q, state_d;
  logic [6:0] upper_pos_q, lower_pos_q, col_upper_q, col_lower_q;
  logic       upper_dir_q, lower_dir_q;
  logic       dir_enable_q, col_valid_q, busy_q, overrun_q;
  logic [7:0] col_x_q;

  // step results, applied only in STEP
  logic signed [7:0] up_s, lo_s, cu, cl, gap;
  logic [6:0]        upper_pos_d, lower_pos_d;
  logic              upper_dir_d, lower_dir_d;

  // Next-state: fixed four-cycle walk to EMIT, then wait for the handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (frame_tick && run) state_d = S_ENABLE;
      S_ENABLE: state_d = S_SAMPLE;
      S_SAMPLE: state_d = S_STEP;
      S_STEP:   state_d = S_EMIT;
      S_EMIT:   if (col_valid_q && col_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // One-pixel step in signed arithmetic: edge clamps first, then the gap holds (upper yields before lower)
  always_comb begin
    up_s        = signed'({1'b0, upper_pos_q});
    lo_s        = signed'({1'b0, lower_pos_q});
    upper_dir_d = upper_dir_q;
    lower_dir_d = lower_dir_q;
    cu          = upper_dir_q ? (up_s - 8'sd1) : (up_s + 8'sd1);
    cl          = lower_dir_q ? (lo_s - 8'sd1) : (lo_s + 8'sd1);
    if (upper_dir_q && (upper_pos_q == 7'd0)) begin
      cu          = up_s;
      upper_dir_d = 1'b0;
    end
    if (!lower_dir_q && (lo_s == BOTTOM_S)) begin
      cl          = lo_s;
      lower_dir_d = 1'b1;
    end
    gap = cl - cu;
    if (gap < GAP_S) begin
      cu  = up_s;
      gap = cl - cu;
      if (gap < GAP_S) cl = lo_s;
    end
    upper_pos_d = cu[6:0];
    lower_pos_d = cl[6:0];
  end

  // State, registered outputs derived from the next state, and per-state register updates
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      upper_pos_q  <= RST_UP;
      lower_pos_q  <= RST_LO;
      upper_dir_q  <= 1'b1;
      lower_dir_q  <= 1'b0;
      col_upper_q  <= RST_UP;
      col_lower_q  <= RST_LO;
      col_x_q      <= 8'd0;
      dir_enable_q <= 1'b0;
      col_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_enable_q <= (state_d == S_ENABLE);
      col_valid_q  <= (state_d == S_EMIT);
      busy_q       <= (state_d != S_IDLE);
      overrun_q    <= frame_tick && run && (state_q != S_IDLE);
      if (state_q == S_SAMPLE) begin
        upper_dir_q <= upper_dir_q ^ toggle_upper;
        lower_dir_q <= lower_dir_q ^ toggle_lower;
      end
      if (state_q == S_STEP) begin
        upper_pos_q <= upper_pos_d;
        lower_pos_q <= lower_pos_d;
        upper_dir_q <= upper_dir_d;
        lower_dir_q <= lower_dir_d;
        col_upper_q <= upper_pos_d;
        col_lower_q <= lower_pos_d;
      end
      if ((state_q == S_EMIT) && col_valid_q && col_ready) begin
        col_x_q <= (col_x_q == LAST_X) ? 8'd0 : col_x_q + 8'd1;
      end
    end
  end

  assign dir_enable = dir_enable_q;
  assign upper_pos  = upper_pos_q;
  assign lower_pos  = lower_pos_q;
  assign upper_dir  = upper_dir_q;
  assign lower_dir  = lower_dir_q;
  assign col_valid  = col_valid_q;
  assign col_x      = col_x_q;
  assign col_upper  = col_upper_q;
  assign col_lower  = col_lower_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_hallway_column_sequencer.sv
// Directed bench for hallway_column_sequencer: reset, stepping, clamps, gap holds, backpressure, wrap, async reset.
// Inputs are driven at the falling edge; outputs are sampled at the falling edge.
// col_ready is held high except in the backpressure and mid-EMIT reset scenarios.
module tb_hallway_column_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       frame_tick, run, toggle_upper, toggle_lower, col_ready;
  logic       dir_enable, upper_dir, lower_dir, col_valid, busy, overrun;
  logic [6:0] upper_pos, lower_pos, col_upper, col_lower;
  logic [7:0] col_x;

  int checks = 0;
  int errors = 0;

  hallway_column_sequencer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .frame_tick   (frame_tick),
    .run          (run),
    .toggle_upper (toggle_upper),
    .toggle_lower (toggle_lower),
    .dir_enable   (dir_enable),
    .upper_pos    (upper_pos),
    .lower_pos    (lower_pos),
    .upper_dir    (upper_dir),
    .lower_dir    (lower_dir),
    .col_valid    (col_valid),
    .col_ready    (col_ready),
    .col_x        (col_x),
    .col_upper    (col_upper),
    .col_lower    (col_lower),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clock = ~clock;

  task automatic do_reset();
    reset_n = 1'b0; frame_tick = 1'b0; run = 1'b1;
    toggle_upper = 1'b0; toggle_lower = 1'b0; col_ready = 1'b1;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  // Issue one tick with col_ready high; return the offered column, tick-to-valid latency and dir_enable count.
  task automatic run_column(output logic [6:0] cu, output logic [6:0] cl, output logic [7:0] cx,
                            output int lat, output int de_cnt);
    de_cnt = 0;
    lat = 0;
    @(negedge clock);
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    de_cnt += int'(dir_enable);
    while (!col_valid && lat < 20) begin
      @(negedge clock);
      de_cnt += int'(dir_enable);
      lat++;
    end
    if (!col_valid) begin
      checks++; errors++;
      $display("FAIL col_valid_timeout got=%0b want=1", col_valid);
    end
    cu = col_upper; cl = col_lower; cx = col_x;
    @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (upper_pos !== 7'd20) begin errors++; $display("FAIL rst_upper_pos got=%0d want=20", upper_pos); end
    checks++; if (lower_pos !== 7'd99) begin errors++; $display("FAIL rst_lower_pos got=%0d want=99", lower_pos); end
    checks++; if (upper_dir !== 1'b1) begin errors++; $display("FAIL rst_upper_dir got=%0b want=1", upper_dir); end
    checks++; if (lower_dir !== 1'b0) begin errors++; $display("FAIL rst_lower_dir got=%0b want=0", lower_dir); end
    checks++; if (col_x !== 8'd0) begin errors++; $display("FAIL rst_col_x got=%0d want=0", col_x); end
    checks++; if (col_valid !== 1'b0) begin errors++; $display("FAIL rst_col_valid got=%0b want=0", col_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0b want=0", busy); end
    checks++; if (dir_enable !== 1'b0) begin errors++; $display("FAIL rst_dir_enable got=%0b want=0", dir_enable); end
    checks++; if ({col_upper, col_lower} !== {7'd20, 7'd99}) begin errors++; $display("FAIL rst_col_edges got=%0d/%0d want=20/99", col_upper, col_lower); end
  endtask

  task automatic test_single_tick();
    logic [6:0] cu, cl; logic [7:0] cx; int lat, de;
    do_reset();
    run_column(cu, cl, cx, lat, de);
    checks++; if (de !== 1) begin errors++; $display("FAIL single_dir_enable_cycles got=%0d want=1", de); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL single_latency got=%0d want=3", lat); end
    checks++; if (cx !== 8'd0) begin errors++; $display("FAIL single_col_x got=%0d want=0", cx); end
    checks++; if (cu !== 7'd19) begin errors++; $display("FAIL single_col_upper got=%0d want=19", cu); end
    checks++; if (cl !== 7'd100) begin errors++; $display("FAIL single_col_lower got=%0d want=100", cl); end
    checks++; if (col_x !== 8'd1) begin errors++; $display("FAIL single_col_x_after got=%0d want=1", col_x); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got=%0b want=0", busy); end
    checks++; if (col_valid !== 1'b0) begin errors++; $display("FAIL single_valid_after got=%0b want=0", col_valid); end
  endtask

  task automatic test_clamp();
    logic [6:0] cu, cl; logic [7:0] cx; int lat, de;
    do_reset();
    for (int t = 1; t <= 21; t++) begin
      run_column(cu, cl, cx, lat, de);
      if (t == 20) begin
        checks++; if ({cu, cl} !== {7'd0, 7'd119}) begin errors++; $display("FAIL clamp_tick20 got=%0d/%0d want=0/119", cu, cl); end
      end
    end
    checks++; if ({cu, cl} !== {7'd0, 7'd119}) begin errors++; $display("FAIL clamp_tick21 got=%0d/%0d want=0/119", cu, cl); end
    checks++; if ({upper_pos, lower_pos} !== {7'd0, 7'd119}) begin errors++; $display("FAIL clamp_pos got=%0d/%0d want=0/119", upper_pos, lower_pos); end
    checks++; if ({upper_dir, lower_dir} !== 2'b01) begin errors++; $display("FAIL clamp_dirs got=%0b%0b want=01", upper_dir, lower_dir); end
  endtask

  task automatic test_gap();
    logic [6:0] cu, cl; logic [7:0] cx; int lat, de; int min_gap;
    do_reset();
    min_gap = 999;
    for (int t = 1; t <= 28; t++) begin
      toggle_upper = (t == 1); toggle_lower = (t == 1);
      run_column(cu, cl, cx, lat, de);
      toggle_upper = 1'b0; toggle_lower = 1'b0;
      if (int'(cl) - int'(cu) < min_gap) min_gap = int'(cl) - int'(cu);
      if (t == 1) begin
        checks++; if ({cu, cl} !== {7'd21, 7'd98}) begin errors++; $display("FAIL gap_tick1 got=%0d/%0d want=21/98", cu, cl); end
      end
      if (t == 26) begin
        checks++; if ({cu, cl} !== {7'd46, 7'd73}) begin errors++; $display("FAIL gap_tick26 got=%0d/%0d want=46/73", cu, cl); end
      end
      if (t == 27) begin
        checks++; if ({cu, cl} !== {7'd46, 7'd72}) begin errors++; $display("FAIL gap_tick27 got=%0d/%0d want=46/72", cu, cl); end
      end
      if (t == 28) begin
        checks++; if ({cu, cl} !== {7'd46, 7'd72}) begin errors++; $display("FAIL gap_tick28 got=%0d/%0d want=46/72", cu, cl); end
      end
    end
    checks++; if (min_gap < 26) begin errors++; $display("FAIL gap_min got=%0d want>=26", min_gap); end
  endtask

  task automatic test_run_low();
    int seen_busy, seen_ovr;
    do_reset();
    seen_busy = 0; seen_ovr = 0;
    run = 1'b0;
    @(negedge clock); frame_tick = 1'b1;
    @(negedge clock); frame_tick = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen_busy += int'(busy); seen_ovr += int'(overrun);
      @(negedge clock);
    end
    run = 1'b1;
    checks++; if (seen_busy !== 0) begin errors++; $display("FAIL runlow_busy got=%0d want=0", seen_busy); end
    checks++; if (seen_ovr !== 0) begin errors++; $display("FAIL runlow_overrun got=%0d want=0", seen_ovr); end
  endtask

  task automatic test_backpressure();
    logic [6:0] cu, cl; logic [7:0] cx; int n, changed, extra;
    do_reset();
    col_ready = 1'b0;
    @(negedge clock); frame_tick = 1'b1;
    @(negedge clock); frame_tick = 1'b0;
    n = 0;
    while (!col_valid && n < 20) begin @(negedge clock); n++; end
    checks++; if (col_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout got=%0b want=1", col_valid); end
    cu = col_upper; cl = col_lower; cx = col_x;
    changed = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (col_valid !== 1'b1 || col_upper !== cu || col_lower !== cl || col_x !== cx) changed++;
      if (i == 2) frame_tick = 1'b1;
      if (i == 3) begin
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun_pulse got=%0b want=1", overrun); end
        frame_tick = 1'b0;
      end
      if (i == 4) begin
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp_overrun_clear got=%0b want=0", overrun); end
      end
    end
    checks++; if (changed !== 0) begin errors++; $display("FAIL bp_stable got=%0d changes want=0", changed); end
    checks++; if ({cu, cl} !== {7'd19, 7'd100}) begin errors++; $display("FAIL bp_fields got=%0d/%0d want=19/100", cu, cl); end
    col_ready = 1'b1;
    @(negedge clock);
    checks++; if (col_x !== 8'd1) begin errors++; $display("FAIL bp_col_x got=%0d want=1", col_x); end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      extra += int'(col_valid) + int'(busy);
      @(negedge clock);
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL bp_extra_column got=%0d want=0", extra); end
  endtask

  task automatic test_wrap();
    logic [6:0] cu, cl; logic [7:0] cx; int lat, de;
    do_reset();
    for (int i = 0; i < 160; i++) begin
      run_column(cu, cl, cx, lat, de);
      checks++; if (cx !== 8'(i)) begin errors++; $display("FAIL wrap_col_x got=%0d want=%0d", cx, i); end
    end
    checks++; if (col_x !== 8'd0) begin errors++; $display("FAIL wrap_after got=%0d want=0", col_x); end
  endtask

  task automatic test_reset_mid_emit();
    logic [6:0] cu, cl; logic [7:0] cx; int lat, de, n;
    do_reset();
    run_column(cu, cl, cx, lat, de);
    col_ready = 1'b0;
    @(negedge clock); frame_tick = 1'b1;
    @(negedge clock); frame_tick = 1'b0;
    n = 0;
    while (!col_valid && n < 20) begin @(negedge clock); n++; end
    checks++; if (col_valid !== 1'b1) begin errors++; $display("FAIL rme_valid_timeout got=%0b want=1", col_valid); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (col_valid !== 1'b0) begin errors++; $display("FAIL rme_col_valid got=%0b want=0", col_valid); end
    checks++; if (col_x !== 8'd0) begin errors++; $display("FAIL rme_col_x got=%0d want=0", col_x); end
    checks++; if ({upper_pos, lower_pos} !== {7'd20, 7'd99}) begin errors++; $display("FAIL rme_pos got=%0d/%0d want=20/99", upper_pos, lower_pos); end
    checks++; if ({upper_dir, lower_dir, busy} !== 3'b100) begin errors++; $display("FAIL rme_dirs_busy got=%b want=100", {upper_dir, lower_dir, busy}); end
    @(negedge clock);
    reset_n = 1'b1;
    col_ready = 1'b1;
    @(negedge clock);
    checks++; if ({col_valid, busy} !== 2'b00) begin errors++; $display("FAIL rme_after got=%b want=00", {col_valid, busy}); end
  endtask

  initial begin
    test_reset();
    test_single_tick();
    test_clamp();
    test_gap();
    test_run_low();
    test_backpressure();
    test_wrap();
    test_reset_mid_emit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
